// File: rtl/divider_if.sv
// Handshake and result bundle for the restoring divider.
// The master drives requests; the slave (divider) returns results and status.
interface divider_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Unsigned W-bit restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_DETECT_EN short-cuts zero divisors and raises div_by_zero.
module divider #(
  parameter int W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  divider_if.slave   bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  dvs_q,   dvs_d;   // latched divisor
  logic [W-1:0]  acc_q,   acc_d;   // dividend bits shift out, quotient bits shift in
  logic [W-1:0]  rem_q,   rem_d;   // partial remainder between steps (always < divisor)
  logic [W-1:0]  quo_q,   quo_d;
  logic [W-1:0]  remo_q,  remo_d;
  logic          dbz_q,   dbz_d;

  logic [W:0]    part_rem;
  logic [W:0]    part_sub;
  logic          q_bit;

  // One restoring step: bring down the next dividend bit, try to subtract.
  assign part_rem = {rem_q, acc_q[W-1]};
  assign part_sub = part_rem - {1'b0, dvs_q};
  assign q_bit    = (part_rem >= {1'b0, dvs_q});

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvs_d   = bus.divisor;
          acc_d   = bus.dividend;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        rem_d = q_bit ? part_sub[W-1:0] : part_rem[W-1:0];
        acc_d = {acc_q[W-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          quo_d   = {acc_q[W-2:0], q_bit};
          remo_d  = q_bit ? part_sub[W-1:0] : part_rem[W-1:0];
          dbz_d   = 1'b0;
          state_d = FIN;
        end
`ifdef DIV_ZERO_DETECT_EN
        // Zero divisor: the restoring result is known up front, skip the iterations.
        if (dvs_q == '0) begin
          quo_d   = '1;
          remo_d  = acc_q;
          dbz_d   = 1'b1;
          state_d = FIN;
        end
`endif
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: all registers, datapath included, are reset so no X reaches the outputs after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = remo_q;
  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == FIN);
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: transaction-level model checked every cycle,
// plus directed cases with literal expectations.
module tb_divider;
  localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_if #(.W(W)) bus ();
  divider #(.W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a division takes W cycles (1 for a detected zero
  // divisor), then a one-cycle result pulse; results come from / and %.
  logic [W-1:0] m_a, m_b, m_q, m_r;
  bit           m_busy, m_done, m_dbz;
  int           m_left;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_busy = 0; m_done = 0; m_q = '0; m_r = '0; m_dbz = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        if (m_b == 0) begin
          m_q = '1; m_r = m_a; m_dbz = DZ;
        end else begin
          m_q = m_a / m_b; m_r = m_a % m_b; m_dbz = 0;
        end
      end
    end else if (bus.start) begin
      m_a    = bus.dividend;
      m_b    = bus.divisor;
      m_busy = 1;
      m_left = (DZ && bus.divisor == 0) ? 1 : W;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy",        32'(bus.busy),        32'(m_busy));
      check("done",        32'(bus.done),        32'(m_done));
      check("quotient",    32'(bus.quotient),    32'(m_q));
      check("remainder",   32'(bus.remainder),   32'(m_r));
      check("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
      check("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
      if (bus.done && m_b != 0) begin
        check("identity", 32'(bus.quotient) * 32'(m_b) + 32'(bus.remainder), 32'(m_a));
        check("rem_lt_div", 32'(bus.remainder < m_b), 32'd1);
      end
    end
  end

  // Issue one request, wait (bounded) for the result pulse and check literals.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input bit edbz, input int exp_busy);
    int busy_n = 0;
    bit seen   = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (bus.done) seen = 1;
      else begin
        if (bus.busy) busy_n++;
        @(negedge clk);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("lit_quotient",  32'(bus.quotient),    32'(eq));
    check("lit_remainder", 32'(bus.remainder),   32'(er));
    check("lit_dbz",       32'(bus.div_by_zero), 32'(edbz));
    check("busy_cycles",   32'(busy_n),          32'(exp_busy));
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient",  32'(bus.quotient),  32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    rst = 1'b0;

    run_div(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, W);
    run_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, W);
    run_div(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, W);
    run_div(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, W);
    run_div(8'd128, 8'd16,  8'd8,   8'd0,   1'b0, W);
    run_div(8'd42,  8'd0,   8'hFF,  8'd42,  DZ,   DZ ? 1 : W);

    // Reset in the middle of a division: no result pulse, outputs cleared.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_quotient",  32'(bus.quotient),  32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    repeat (10) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, W);

    // Second request held through the whole operation and the result cycle.
    begin
      bit seen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      @(negedge clk);
      bus.dividend = 8'd99; bus.divisor = 8'd9;
      for (int t = 0; t < 40 && !seen; t++) begin
        if (bus.done) seen = 1;
        else @(negedge clk);
      end
      check("held_done_seen", 32'(seen), 32'd1);
      check("held_quotient",  32'(bus.quotient),  32'd10);
      check("held_remainder", 32'(bus.remainder), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      check("fin_start_ignored", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Random traffic, including starts while busy, zero divisors and resets.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.dividend = W'($urandom);
      bus.divisor  = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      rst          = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (unsigned).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset is synchronous and active-high.
REQ-004 START  input  1  request a division; sampled only in IDLE.
REQ-005 DIVIDEND  input  W  numerator; latched on accepted START.
REQ-006 DIVISOR  input  W  denominator; latched on accepted START.
REQ-007 QUOTIENT  output  W  registered quotient.
REQ-008 REMAINDER  output  W  registered remainder.
REQ-009 BUSY  output  1  high while a division is in progress (CALC state).
REQ-010 DONE  output  1  one-cycle pulse; results valid.
REQ-011 DIV_BY_ZERO  output  1  latched divisor==0 flag for the current result.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, FIN.
REQ-013 In IDLE with START=1 at edge k, the block SHALL latch DIVIDEND/DIVISOR, clear its iteration counter, enter CALC, and assert BUSY from edge k.
REQ-014 In CALC, the block SHALL perform one restoring shift-subtract step per cycle, MSB first, using a (W+1)-bit partial remainder; if the partial remainder >= divisor, it SHALL subtract and set the quotient bit to 1, otherwise it SHALL set the quotient bit to 0.
REQ-015 After exactly W CALC steps (edges k+1..k+W), the block SHALL enter FIN: BUSY=0, DONE=1 for that single cycle, and QUOTIENT/REMAINDER updated with final values.
REQ-016 FIN SHALL return to IDLE on the next edge unconditionally; START during FIN SHALL be ignored.
REQ-017 START while BUSY=1 SHALL be ignored; the latched operands SHALL NOT change.
REQ-018 QUOTIENT, REMAINDER and DIV_BY_ZERO SHALL hold their values from FIN until the next FIN or RESET; they SHALL NOT show intermediate values during CALC.
REQ-019 The arithmetic SHALL satisfy DIVIDEND == QUOTIENT*DIVISOR + REMAINDER with REMAINDER < DIVISOR for DIVISOR != 0.
REQ-020 For DIVISOR == 0, the result SHALL be QUOTIENT = all ones and REMAINDER = DIVIDEND (the natural restoring result).
REQ-021 DONE and BUSY SHALL never be high in the same cycle.

Reset
REQ-022 RESET=1 at an edge SHALL force IDLE and set QUOTIENT=0, REMAINDER=0, BUSY=0, DONE=0, DIV_BY_ZERO=0.
REQ-023 RESET SHALL have priority over START, and RESET in any state SHALL abort the operation without a DONE pulse.

Configuration
REQ-024 Macro DIV_ZERO_DETECT_EN defined: a DIVISOR of 0 at an accepted START SHALL skip CALC, go straight to FIN on edge k+1 (DONE one cycle after acceptance), and set DIV_BY_ZERO=1 with the REQ-020 result.
REQ-025 Macro DIV_ZERO_DETECT_EN undefined: a zero divisor SHALL run the full W-step CALC, giving the REQ-020 result, and DIV_BY_ZERO SHALL be tied to 0.
REQ-026 Nonzero-divisor behaviour and latency SHALL be identical with or without the macro.

Verification (W=8)
REQ-027 START with 100/7 -> DONE high in the cycle after edge k+8; QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0; BUSY high for exactly 8 cycles.
REQ-028 Back-to-back cases 255/1 -> 255,0; 5/9 -> 0,5; 255/255 -> 1,0; 128/16 -> 8,0; each DONE pulse is exactly one cycle wide.
REQ-029 42/0 with DIV_ZERO_DETECT_EN -> DONE after edge k+1, QUOTIENT=255, REMAINDER=42, DIV_BY_ZERO=1; without the macro -> DONE after edge k+8, the same values, DIV_BY_ZERO=0.
REQ-030 START 200/3, then RESET at edge k+4 -> all outputs 0, no DONE pulse; a new START 9/2 -> 4,1 with normal latency.
REQ-031 START 50/5, then START 99/9 held during CALC -> 10,0 is reported; the second request is ignored until IDLE is reached.
REQ-032 Random unsigned operand sweep (divisor != 0) -> the REQ-019 identity holds for every DONE pulse.
